// File: rtl/alien_formation_mover.sv
// Motion controller for one alien formation. It sweeps x between X_MIN and X_MAX, drops y at each edge and stops at Y_LIMIT.
// Optional feature macro: ALIEN_SPEEDUP_EN (each completed drop shortens the step period, floored at MIN_FRAMES).
module alien_formation_mover #(
    parameter int unsigned X_W        = 8,
    parameter int unsigned Y_W        = 7,
    parameter int unsigned X_MIN      = 50,
    parameter int unsigned X_MAX      = 58,
    parameter int unsigned Y_START    = 15,
    parameter int unsigned Y_LIMIT    = 111,
    parameter int unsigned STEP       = 1,
    parameter int unsigned DROP       = 4,
    parameter int unsigned TICK_DIV   = 833334,
    parameter int unsigned FRAMES     = 15,
    parameter int unsigned MIN_FRAMES = 2
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           go,
    input  logic           halt,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           dir,
    output logic           busy,
    output logic           step,
    output logic           done
);

    localparam int unsigned TW   = $clog2(TICK_DIV + 1);
    localparam int unsigned FMAX = (FRAMES > MIN_FRAMES) ? FRAMES : MIN_FRAMES;
    localparam int unsigned FW   = $clog2(FMAX + 1);

    if (X_MAX <= X_MIN)   begin : g_bad_x     $error("X_MAX must exceed X_MIN");   end
    if (Y_LIMIT <= Y_START) begin : g_bad_y   $error("Y_LIMIT must exceed Y_START"); end
    if (STEP < 1)         begin : g_bad_step  $error("STEP must be at least 1");   end
    if (DROP < 1)         begin : g_bad_drop  $error("DROP must be at least 1");   end
    if (TICK_DIV < 1)     begin : g_bad_tick  $error("TICK_DIV must be at least 1"); end
    if (FRAMES < 1)       begin : g_bad_frm   $error("FRAMES must be at least 1"); end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RIGHT  = 3'd1,
        S_DROP_L = 3'd2,
        S_LEFT   = 3'd3,
        S_DROP_R = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic            dir_q, dir_d, busy_q, busy_d, step_q, step_d, done_q, done_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [FW-1:0]   frame_q, frame_d, fps_q, fps_d;

    logic            run_s, tick_wrap_s, frame_wrap_s, strobe_s, x_can_dec_s, y_end_s;
    logic [X_W:0]    x_inc_s;
    logic [Y_W:0]    y_inc_s;

    // Next-state logic: prescaler, sweep/drop sequencing and registered output values
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        tick_d  = tick_q;
        frame_d = frame_q;
        fps_d   = fps_q;
        step_d  = 1'b0;
        done_d  = 1'b0;

        run_s        = ((state_q == S_RIGHT) || (state_q == S_LEFT)) && !halt;
        tick_wrap_s  = (tick_q >= TW'(TICK_DIV - 1));
        frame_wrap_s = (frame_q >= (fps_q - FW'(1)));
        strobe_s     = run_s && tick_wrap_s && frame_wrap_s;
        x_inc_s      = {1'b0, x_q} + (X_W+1)'(STEP);
        x_can_dec_s  = ({1'b0, x_q} >= (X_W+1)'(X_MIN + STEP));
        y_inc_s      = {1'b0, y_q} + (Y_W+1)'(DROP);
        y_end_s      = (y_inc_s >= (Y_W+1)'(Y_LIMIT));

        // Both counters wrap together on the strobe, so a drop always starts a fresh step period
        if (run_s) begin
            if (tick_wrap_s) begin
                tick_d = {TW{1'b0}};
                if (frame_wrap_s) begin
                    frame_d = {FW{1'b0}};
                end else begin
                    frame_d = frame_q + FW'(1);
                end
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end else begin
            tick_d = tick_q;
        end

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_RIGHT;
                    x_d     = X_W'(X_MIN);
                    y_d     = Y_W'(Y_START);
                    dir_d   = 1'b1;
                    tick_d  = {TW{1'b0}};
                    frame_d = {FW{1'b0}};
                    fps_d   = FW'(FRAMES);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RIGHT: begin
                if (strobe_s) begin
                    step_d = 1'b1;
                    if (x_inc_s <= (X_W+1)'(X_MAX)) begin
                        x_d = x_inc_s[X_W-1:0];
                    end else begin
                        x_d     = X_W'(X_MAX);
                        state_d = S_DROP_L;
                    end
                end else begin
                    state_d = S_RIGHT;
                end
            end
            S_LEFT: begin
                if (strobe_s) begin
                    step_d = 1'b1;
                    if (x_can_dec_s) begin
                        x_d = x_q - X_W'(STEP);
                    end else begin
                        x_d     = X_W'(X_MIN);
                        state_d = S_DROP_R;
                    end
                end else begin
                    state_d = S_LEFT;
                end
            end
            S_DROP_L, S_DROP_R: begin
                if (!halt) begin
`ifdef ALIEN_SPEEDUP_EN
                    if (fps_q > FW'(MIN_FRAMES)) begin
                        fps_d = fps_q - FW'(1);
                    end else begin
                        fps_d = fps_q;
                    end
`else
                    fps_d = fps_q;
`endif
                    if (y_end_s) begin
                        y_d     = Y_W'(Y_LIMIT);
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        y_d     = y_inc_s[Y_W-1:0];
                        state_d = (state_q == S_DROP_L) ? S_LEFT : S_RIGHT;
                        dir_d   = (state_q == S_DROP_R);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RIGHT) || (state_d == S_DROP_L) ||
                 (state_d == S_LEFT)  || (state_d == S_DROP_R);
    end

    // State, position and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            x_q     <= X_W'(X_MIN);
            y_q     <= Y_W'(Y_START);
            dir_q   <= 1'b1;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            tick_q  <= {TW{1'b0}};
            frame_q <= {FW{1'b0}};
            fps_q   <= FW'(FRAMES);
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
            fps_q   <= fps_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign dir  = dir_q;
    assign busy = busy_q;
    assign step = step_q;
    assign done = done_q;

endmodule

// File: tb/tb_alien_formation_mover.sv
// Self-checking bench for alien_formation_mover: vector table, directed corner sequences and random stimulus
// compared each cycle against a phase/elapsed-cycle reference model.
module tb_alien_formation_mover;

    localparam int TD = 2;
`ifdef ALIEN_SPEEDUP_EN
    localparam int FR = 4;
`else
    localparam int FR = 2;
`endif
    localparam int MINF  = 2;
    localparam int XMIN  = 50;
    localparam int XMAX  = 58;
    localparam int YST   = 15;
    localparam int YLIM  = 111;
    localparam int STEPV = 1;
    localparam int DROPV = 4;

    logic       clk = 1'b0;
    logic       resetn, go, halt;
    logic [7:0] x;
    logic [6:0] y;
    logic       dir, busy, step, done;

    alien_formation_mover #(
        .X_W(8), .Y_W(7), .X_MIN(XMIN), .X_MAX(XMAX), .Y_START(YST), .Y_LIMIT(YLIM),
        .STEP(STEPV), .DROP(DROPV), .TICK_DIV(TD), .FRAMES(FR), .MIN_FRAMES(MINF)
    ) dut (
        .clk(clk), .resetn(resetn), .go(go), .halt(halt),
        .x(x), .y(y), .dir(dir), .busy(busy), .step(step), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum {PH_IDLE, PH_MOVE, PH_DROP, PH_DONE} phase_t;
    phase_t m_ph;
    int     m_x, m_y, m_fps, m_el;
    bit     m_dir, m_step, m_done;

    typedef struct {
        bit go; bit halt; int n;
        int ex; int ey; bit edir; bit ebusy; bit estep;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = PH_IDLE; m_x = XMIN; m_y = YST; m_dir = 1'b1;
        m_el = 0; m_fps = FR; m_step = 1'b0; m_done = 1'b0;
    endtask

    // One clock edge of the game-level behaviour: a step every TD*fps running cycles
    task automatic model_step(input bit g, input bit h);
        m_step = 1'b0;
        m_done = 1'b0;
        case (m_ph)
            PH_IDLE: if (g) begin
                m_ph = PH_MOVE; m_x = XMIN; m_y = YST; m_dir = 1'b1; m_el = 0; m_fps = FR;
            end
            PH_MOVE: if (!h) begin
                m_el++;
                if (m_el == TD * m_fps) begin
                    m_el = 0;
                    m_step = 1'b1;
                    if (m_dir) begin
                        if (m_x + STEPV <= XMAX) m_x += STEPV;
                        else begin m_x = XMAX; m_ph = PH_DROP; end
                    end else begin
                        if (m_x - STEPV >= XMIN) m_x -= STEPV;
                        else begin m_x = XMIN; m_ph = PH_DROP; end
                    end
                end
            end
            PH_DROP: if (!h) begin
`ifdef ALIEN_SPEEDUP_EN
                if (m_fps > MINF) m_fps--;
`endif
                if (m_y + DROPV >= YLIM) begin
                    m_y = YLIM; m_ph = PH_DONE; m_done = 1'b1;
                end else begin
                    m_y += DROPV; m_dir = !m_dir; m_ph = PH_MOVE;
                end
            end
            PH_DONE: m_ph = PH_IDLE;
            default: m_ph = PH_IDLE;
        endcase
    endtask

    task automatic compare_all(input string tag);
        logic [18:0] act, exp;
        bit          eb;
        eb  = (m_ph == PH_MOVE) || (m_ph == PH_DROP);
        act = {x, y, dir, busy, step, done};
        exp = {8'(m_x), 7'(m_y), m_dir, eb, m_step, m_done};
        check(tag, int'(act), int'(exp));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        if (resetn) model_step(go, halt);
        #1;
        compare_all(tag);
    endtask

    vec_t tbl[13];
    int   drops, prev_y;
    bit   seen;
    int   stimes[$];
    int   c;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 20, 50, 15, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0,  1, 50, 15, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0,  4, 51, 15, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 28, 58, 15, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0,  4, 58, 15, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0,  1, 58, 19, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0,  4, 57, 19, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0,  1, 57, 19, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 37, 57, 19, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0,  2, 57, 19, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0,  1, 56, 19, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b0,  3, 56, 19, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0,  1, 55, 19, 1'b0, 1'b1, 1'b1};

        resetn = 1'b0; go = 1'b0; halt = 1'b0;
        model_reset();
        #1;
        repeat (2) cyc("reset");
        check("rst.x", int'(x), 50);
        check("rst.y", int'(y), 15);
        check("rst.dir", int'(dir), 1);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        resetn = 1'b1;

`ifndef ALIEN_SPEEDUP_EN
        // Idle, first sweep, edge drop, halt freeze and go-while-busy
        for (int i = 0; i < 13; i++) begin
            go = tbl[i].go; halt = tbl[i].halt;
            repeat (tbl[i].n) cyc("model");
            check($sformatf("tbl%0d.x", i), int'(x), tbl[i].ex);
            check($sformatf("tbl%0d.y", i), int'(y), tbl[i].ey);
            check($sformatf("tbl%0d.dir", i), int'(dir), int'(tbl[i].edir));
            check($sformatf("tbl%0d.busy", i), int'(busy), int'(tbl[i].ebusy));
            check($sformatf("tbl%0d.step", i), int'(step), int'(tbl[i].estep));
        end
        go = 1'b0; halt = 1'b0;
`else
        go = 1'b1; cyc("model"); go = 1'b0;
        repeat (30) cyc("model");
`endif

        // Asynchronous reset between clock edges in the middle of a sweep
        cyc("model");
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        check("arst.x", int'(x), 50);
        check("arst.y", int'(y), 15);
        check("arst.dir", int'(dir), 1);
        check("arst.busy", int'(busy), 0);
        check("arst.done", int'(done), 0);
        repeat (3) cyc("arst_hold");
        resetn = 1'b1;
        repeat (2) cyc("model");

        // Full run to the bottom limit
        go = 1'b1; cyc("model"); go = 1'b0;
        drops = 0; prev_y = int'(y); seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            cyc("model");
            if (int'(y) != prev_y) drops++;
            prev_y = int'(y);
            if (done) seen = 1'b1;
        end
        check("run.done_seen", int'(seen), 1);
        check("run.drops", drops, 24);
        check("run.y_end", int'(y), 111);
        check("run.x_end", int'(x), 50);
        check("run.busy_end", int'(busy), 0);
        cyc("model");
        check("run.done_len", int'(done), 0);
        repeat (5) cyc("model");
        check("run.x_hold", int'(x), 50);
        check("run.y_hold", int'(y), 111);
        go = 1'b1; halt = 1'b1;
        cyc("model");
        go = 1'b0; halt = 1'b0;
        check("restart.x", int'(x), 50);
        check("restart.y", int'(y), 15);
        check("restart.busy", int'(busy), 1);

`ifdef ALIEN_SPEEDUP_EN
        // Step period shrinks 8 -> 6 -> 4 cycles over the first drops
        resetn = 1'b0; model_reset();
        cyc("model");
        resetn = 1'b1;
        go = 1'b1; cyc("model"); go = 1'b0;
        c = 0;
        for (int i = 0; i < 1000 && stimes.size() < 41; i++) begin
            cyc("model");
            c++;
            if (step) stimes.push_back(c);
        end
        check("spd.steps_seen", int'(stimes.size() >= 41), 1);
        if (stimes.size() >= 41) begin
            check("spd.first", stimes[0], 8);
            check("spd.period0", stimes[2] - stimes[1], 8);
            check("spd.period1", stimes[11] - stimes[10], 6);
            check("spd.period2", stimes[20] - stimes[19], 4);
            check("spd.period4", stimes[40] - stimes[39], 4);
        end
`endif

        // Random go/halt/reset traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            go   = ($urandom_range(7) == 0);
            halt = ($urandom_range(3) == 0);
            if (!resetn) begin
                resetn = 1'b1;
            end else if ($urandom_range(599) == 0) begin
                resetn = 1'b0;
                model_reset();
            end
            cyc("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
